// File: rtl/glitch_burst_if.sv
// Control/status bundle for glitch_burst_gen: configuration and arm/abort in,
// glitch drive and burst status out.
interface glitch_burst_if #(
  parameter int CNT_W = 32,
  parameter int NUM_W = 8
);
  logic             arm;
  logic             abort;
  logic [CNT_W-1:0] cfg_delay;
  logic [CNT_W-1:0] cfg_width;
  logic [CNT_W-1:0] cfg_gap;
  logic [NUM_W-1:0] cfg_count;
  logic             glitch;
  logic             armed;
  logic             delay_active;
  logic             busy;
  logic             done;
  logic [NUM_W-1:0] pulse_idx;

  modport master (
    output arm, abort, cfg_delay, cfg_width, cfg_gap, cfg_count,
    input  glitch, armed, delay_active, busy, done, pulse_idx
  );

  modport slave (
    input  arm, abort, cfg_delay, cfg_width, cfg_gap, cfg_count,
    output glitch, armed, delay_active, busy, done, pulse_idx
  );
endinterface

// File: rtl/glitch_burst_gen.sv
// Trigger-synchronised glitch burst generator: after a configurable delay,
// emits cfg_count pulses of cfg_width cycles separated by cfg_gap idle cycles.
module glitch_burst_gen #(
  parameter int CNT_W         = 32,
  parameter int NUM_W         = 8,
  parameter int SYNC_STAGES   = 2,
  parameter bit GLITCH_ACTIVE = 1'b1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           trigger,
  glitch_burst_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, ARMED, DELAY, GLITCH, GAP, DONE} state_t;

  state_t           state_reg, state_next;
  logic [1:0]       rel_reg;
  logic [SYNC_STAGES-1:0] sync_reg;
  logic             prev_reg;
  logic             trig_edge;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [NUM_W-1:0] idx_reg, idx_next;
  logic [CNT_W-1:0] sh_delay_reg, sh_width_reg, sh_gap_reg;
  logic [NUM_W-1:0] sh_count_reg;
  logic             latch_cfg;
  logic             last_pulse;
  logic             glitch_reg, armed_reg, delay_active_reg, busy_reg, done_reg;

  // Reset release pipeline plus trigger synchroniser and edge history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rel_reg  <= '0;
      sync_reg <= '0;
      prev_reg <= 1'b0;
    end else begin
      rel_reg  <= {rel_reg[0], 1'b1};
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], trigger};
      prev_reg <= sync_reg[SYNC_STAGES-1];
    end
  end

  assign trig_edge  = sync_reg[SYNC_STAGES-1] & ~prev_reg;
  assign last_pulse = ({1'b0, idx_reg} + (NUM_W+1)'(1)) == {1'b0, sh_count_reg};

  // Counters are loaded with length-1 so the all-ones length is honoured without wrap.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    idx_next   = idx_reg;
    latch_cfg  = 1'b0;
    if (bus.abort) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.arm && rel_reg[1] && (bus.cfg_count != '0) && (bus.cfg_width != '0)) begin
            latch_cfg  = 1'b1;
            idx_next   = '0;
            state_next = ARMED;
          end
        end
        ARMED: begin
          if (trig_edge) begin
            if (sh_delay_reg != '0) begin
              state_next = DELAY;
              cnt_next   = sh_delay_reg - CNT_W'(1);
            end else begin
              state_next = GLITCH;
              cnt_next   = sh_width_reg - CNT_W'(1);
            end
          end
        end
        DELAY: begin
          if (cnt_reg == '0) begin
            state_next = GLITCH;
            cnt_next   = sh_width_reg - CNT_W'(1);
          end else begin
            cnt_next = cnt_reg - CNT_W'(1);
          end
        end
        GLITCH: begin
          if (cnt_reg == '0) begin
            if (last_pulse) begin
              state_next = DONE;
            end else begin
              idx_next = idx_reg + NUM_W'(1);
              if (sh_gap_reg == '0) begin
                state_next = GLITCH;
                cnt_next   = sh_width_reg - CNT_W'(1);
              end else begin
                state_next = GAP;
                cnt_next   = sh_gap_reg - CNT_W'(1);
              end
            end
          end else begin
            cnt_next = cnt_reg - CNT_W'(1);
          end
        end
        GAP: begin
          if (cnt_reg == '0) begin
            state_next = GLITCH;
            cnt_next   = sh_width_reg - CNT_W'(1);
          end else begin
            cnt_next = cnt_reg - CNT_W'(1);
          end
        end
        DONE:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Status outputs are registered from the next state so they track state_reg exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= IDLE;
      cnt_reg          <= '0;
      idx_reg          <= '0;
      sh_delay_reg     <= '0;
      sh_width_reg     <= '0;
      sh_gap_reg       <= '0;
      sh_count_reg     <= '0;
      glitch_reg       <= ~GLITCH_ACTIVE;
      armed_reg        <= 1'b0;
      delay_active_reg <= 1'b0;
      busy_reg         <= 1'b0;
      done_reg         <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      if (latch_cfg) begin
        sh_delay_reg <= bus.cfg_delay;
        sh_width_reg <= bus.cfg_width;
        sh_gap_reg   <= bus.cfg_gap;
        sh_count_reg <= bus.cfg_count;
      end
      glitch_reg       <= (state_next == GLITCH) ? GLITCH_ACTIVE : ~GLITCH_ACTIVE;
      armed_reg        <= (state_next == ARMED);
      delay_active_reg <= (state_next == DELAY);
      busy_reg         <= (state_next != IDLE);
      done_reg         <= (state_next == DONE);
    end
  end

  assign bus.glitch       = glitch_reg;
  assign bus.armed        = armed_reg;
  assign bus.delay_active = delay_active_reg;
  assign bus.busy         = busy_reg;
  assign bus.done         = done_reg;
  assign bus.pulse_idx    = idx_reg;

endmodule

// File: tb/tb_glitch_burst_gen.sv
// Directed bench: DUT a (16-bit counters, active-high glitch) and DUT b
// (4-bit counters, active-low glitch) exercised in sequence.
module tb_glitch_burst_gen;

  logic clk = 1'b0;
  logic rst_na, rst_nb;
  logic trig_a, trig_b;
  int   vectors = 0;
  int   miscompares = 0;
  int   done_cnt;
  logic exp_g;

  glitch_burst_if #(.CNT_W(16), .NUM_W(8)) bus_a ();
  glitch_burst_if #(.CNT_W(4),  .NUM_W(4)) bus_b ();

  glitch_burst_gen #(.CNT_W(16), .NUM_W(8), .SYNC_STAGES(2), .GLITCH_ACTIVE(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_na), .trigger(trig_a), .bus(bus_a.slave)
  );

  glitch_burst_gen #(.CNT_W(4), .NUM_W(4), .SYNC_STAGES(2), .GLITCH_ACTIVE(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_nb), .trigger(trig_b), .bus(bus_b.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cfg_a(input int d, input int w, input int g, input int c);
    bus_a.cfg_delay = 16'(d);
    bus_a.cfg_width = 16'(w);
    bus_a.cfg_gap   = 16'(g);
    bus_a.cfg_count = 8'(c);
  endtask

  initial begin
    rst_na = 1'b0; rst_nb = 1'b0; trig_a = 1'b0; trig_b = 1'b0;
    bus_a.arm = 1'b0; bus_a.abort = 1'b0; cfg_a(0, 1, 0, 1);
    bus_b.arm = 1'b0; bus_b.abort = 1'b0;
    bus_b.cfg_delay = '0; bus_b.cfg_width = 4'd1; bus_b.cfg_gap = '0; bus_b.cfg_count = 4'd1;
    repeat (3) tick();

    // Reset state
    check("rst_glitch_a", bus_a.glitch, 1'b0);
    check("rst_busy_a", bus_a.busy, 1'b0);
    check("rst_armed_a", bus_a.armed, 1'b0);
    check("rst_done_a", bus_a.done, 1'b0);
    check("rst_idx_a", bus_a.pulse_idx, 8'd0);
    check("rst_glitch_b", bus_b.glitch, 1'b1);

    // Arm in the first cycle after reset release must be ignored
    rst_na = 1'b1;
    bus_a.arm = 1'b1;
    tick();
    check("arm_early", bus_a.armed, 1'b0);
    bus_a.arm = 1'b0;
    repeat (3) tick();

    // Single pulse: delay 5, width 3
    cfg_a(5, 3, 0, 1);
    bus_a.arm = 1'b1;
    tick();
    bus_a.arm = 1'b0;
    check("s1_armed", bus_a.armed, 1'b1);
    check("s1_busy", bus_a.busy, 1'b1);
    trig_a = 1'b1;
    for (int t = 0; t <= 11; t++) begin
      tick();
      check($sformatf("s1_glitch_t%0d", t), bus_a.glitch, (t >= 7 && t <= 9));
      check($sformatf("s1_delay_t%0d", t), bus_a.delay_active, (t >= 2 && t <= 6));
      check($sformatf("s1_armed_t%0d", t), bus_a.armed, (t < 2));
      check($sformatf("s1_done_t%0d", t), bus_a.done, (t == 10));
      check($sformatf("s1_busy_t%0d", t), bus_a.busy, (t <= 10));
    end
    trig_a = 1'b0;
    repeat (3) tick();

    // Three pulses, width 2, gap 4; cfg and arm changes after latching ignored
    cfg_a(0, 2, 4, 3);
    bus_a.arm = 1'b1;
    tick();
    bus_a.arm = 1'b0;
    cfg_a(1, 7, 0, 1);
    trig_a = 1'b1;
    done_cnt = 0;
    for (int t = 0; t <= 20; t++) begin
      bus_a.arm = (t == 5);
      tick();
      exp_g = (t >= 2 && t <= 15 && ((t - 2) % 6) < 2);
      check($sformatf("s2_glitch_t%0d", t), bus_a.glitch, exp_g);
      if (t == 2 || t == 8 || t == 14)
        check($sformatf("s2_idx_t%0d", t), bus_a.pulse_idx, 8'((t - 2) / 6));
      if (bus_a.done) done_cnt++;
      if (t == 16) check("s2_done_t16", bus_a.done, 1'b1);
    end
    bus_a.arm = 1'b0;
    check("s2_done_count", done_cnt, 1);
    check("s2_busy_end", bus_a.busy, 1'b0);
    trig_a = 1'b0;
    repeat (3) tick();

    // Zero gap: continuous glitch for 4 x 2 cycles
    cfg_a(0, 2, 0, 4);
    bus_a.arm = 1'b1;
    tick();
    bus_a.arm = 1'b0;
    trig_a = 1'b1;
    for (int t = 0; t <= 12; t++) begin
      tick();
      check($sformatf("s3_glitch_t%0d", t), bus_a.glitch, (t >= 2 && t <= 9));
      check($sformatf("s3_done_t%0d", t), bus_a.done, (t == 10));
      if (t == 9) check("s3_idx_t9", bus_a.pulse_idx, 8'd3);
    end
    trig_a = 1'b0;
    repeat (3) tick();

    // Abort during the second pulse
    cfg_a(0, 3, 2, 3);
    bus_a.arm = 1'b1;
    tick();
    bus_a.arm = 1'b0;
    trig_a = 1'b1;
    for (int t = 0; t <= 8; t++) begin
      tick();
      check($sformatf("s4_glitch_t%0d", t), bus_a.glitch, ((t >= 2 && t <= 4) || t >= 7));
    end
    bus_a.abort = 1'b1;
    tick();
    bus_a.abort = 1'b0;
    check("s4_abort_glitch", bus_a.glitch, 1'b0);
    check("s4_abort_busy", bus_a.busy, 1'b0);
    check("s4_abort_done", bus_a.done, 1'b0);
    check("s4_abort_idx", bus_a.pulse_idx, 8'd1);
    done_cnt = 0;
    for (int t = 0; t < 5; t++) begin
      tick();
      if (bus_a.done || bus_a.glitch) done_cnt++;
    end
    check("s4_quiet_after_abort", done_cnt, 0);

    // Abort wins over arm in the same cycle
    cfg_a(0, 1, 0, 1);
    bus_a.arm = 1'b1;
    bus_a.abort = 1'b1;
    tick();
    bus_a.abort = 1'b0;
    check("abort_over_arm", bus_a.armed, 1'b0);
    // Re-arm accepted while trigger already held high: must not fire
    tick();
    bus_a.arm = 1'b0;
    check("rearm_armed", bus_a.armed, 1'b1);
    for (int t = 0; t < 8; t++) begin
      tick();
      check($sformatf("held_trig_glitch_t%0d", t), bus_a.glitch, 1'b0);
    end
    check("held_trig_still_armed", bus_a.armed, 1'b1);
    trig_a = 1'b0;
    repeat (3) tick();
    trig_a = 1'b1;
    for (int t = 0; t <= 3; t++) begin
      tick();
      check($sformatf("rearm_glitch_t%0d", t), bus_a.glitch, (t == 2));
      check($sformatf("rearm_done_t%0d", t), bus_a.done, (t == 3));
    end
    trig_a = 1'b0;
    repeat (3) tick();

    // Zero count / zero width arms are ignored
    cfg_a(0, 3, 0, 0);
    bus_a.arm = 1'b1;
    tick();
    check("count0_armed", bus_a.armed, 1'b0);
    check("count0_busy", bus_a.busy, 1'b0);
    cfg_a(0, 0, 0, 2);
    tick();
    bus_a.arm = 1'b0;
    check("width0_armed", bus_a.armed, 1'b0);
    trig_a = 1'b1;
    repeat (5) tick();
    check("count0_no_glitch", bus_a.glitch, 1'b0);
    check("count0_no_busy", bus_a.busy, 1'b0);

    // DUT b: maximum delay and width (15) with 4-bit counters, active-low glitch
    rst_nb = 1'b1;
    repeat (3) tick();
    bus_b.cfg_delay = 4'd15; bus_b.cfg_width = 4'd15; bus_b.cfg_gap = 4'd0; bus_b.cfg_count = 4'd1;
    bus_b.arm = 1'b1;
    tick();
    bus_b.arm = 1'b0;
    check("b_armed", bus_b.armed, 1'b1);
    trig_b = 1'b1;
    for (int t = 0; t <= 33; t++) begin
      tick();
      check($sformatf("b_glitch_t%0d", t), bus_b.glitch, !(t >= 17 && t <= 31));
      check($sformatf("b_done_t%0d", t), bus_b.done, (t == 32));
    end
    trig_b = 1'b0;
    repeat (3) tick();

    // DUT b: asynchronous reset in the middle of a pulse
    bus_b.cfg_delay = 4'd0; bus_b.cfg_width = 4'd15; bus_b.cfg_count = 4'd2;
    bus_b.arm = 1'b1;
    tick();
    bus_b.arm = 1'b0;
    trig_b = 1'b1;
    repeat (6) tick();
    check("b_mid_glitch", bus_b.glitch, 1'b0);
    #3;
    rst_nb = 1'b0;
    #1;
    check("b_async_glitch", bus_b.glitch, 1'b1);
    check("b_async_busy", bus_b.busy, 1'b0);
    check("b_async_armed", bus_b.armed, 1'b0);
    check("b_async_delay", bus_b.delay_active, 1'b0);
    check("b_async_done", bus_b.done, 1'b0);
    check("b_async_idx", bus_b.pulse_idx, 4'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
